axis_video_out: RTL



---
 rtl/axis_video_out.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/axis_video_out.sv
// axis_video_out: converts an AXI4-Stream video stream into a raster-timed parallel video bus.
// A small pixel FIFO feeds a free-running timing generator; the stream is locked to the raster on TUSER.
module axis_video_out #(
   parameter int unsigned H_ACTIVE   = 1280,
   parameter int unsigned H_FP       = 110,
   parameter int unsigned H_SYNC     = 40,
   parameter int unsigned H_BP       = 220,
   parameter int unsigned V_ACTIVE   = 720,
   parameter int unsigned V_FP       = 5,
   parameter int unsigned V_SYNC     = 5,
   parameter int unsigned V_BP       = 20,
   parameter int unsigned HS_POL     = 1,
   parameter int unsigned VS_POL     = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        enable_i,
   input  logic        s_axis_video_TVALID,
   output logic        s_axis_video_TREADY,
   input  logic [23:0] s_axis_video_TDATA,
   input  logic        s_axis_video_TUSER,
   input  logic        s_axis_video_TLAST,
   output logic [23:0] vid_data_o,
   output logic        vid_de_o,
   output logic        vid_hsync_o,
   output logic        vid_vsync_o,
   output logic        locked_o,
   output logic        underflow_o
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL + 1);
   localparam int unsigned VW      = $clog2(V_TOTAL + 1);
   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned PW      = AW + 1;
   localparam int unsigned DW      = 24;
   localparam logic        HS_ACT  = 1'(HS_POL);
   localparam logic        VS_ACT  = 1'(VS_POL);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LOCKED} state_e;

   typedef struct packed {
      logic          tuser;
      logic          tlast;
      logic [DW-1:0] tdata;
   } beat_t;

   state_e        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] data_q, data_d;
   logic          de_q, de_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          locked_q, locked_d;
   logic          uf_q, uf_d;

   beat_t         fifo_mem [FIFO_DEPTH];
   beat_t         head;
   logic          full, empty, wr_en, pop, flush;
   logic          active, hs_win, vs_win, sof, eol, mismatch;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign s_axis_video_TREADY = enable_i && !full;
   assign wr_en = s_axis_video_TVALID && s_axis_video_TREADY;
   assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

   assign active   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
   assign hs_win   = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_win   = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign sof      = (h_q == '0) && (v_q == '0);
   assign eol      = (h_q == HW'(H_ACTIVE - 1));
   assign mismatch = (head.tuser != sof) || (head.tlast != eol);

   // Storage only; pointers carry the reset state.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= {s_axis_video_TUSER, s_axis_video_TLAST, s_axis_video_TDATA};
      end
   end

   // Timing generator, lock FSM and registered video outputs.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      pop     = 1'b0;
      flush   = 1'b0;
      data_d  = '0;
      de_d    = 1'b0;
      hs_d    = ~HS_ACT;
      vs_d    = ~VS_ACT;
      uf_d    = 1'b0;

      if (!enable_i) begin
         state_d = ST_IDLE;
         h_d     = '0;
         v_d     = '0;
         flush   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_SYNC;
            ST_SYNC, ST_LOCKED: begin
               if (h_q == HW'(H_TOTAL - 1)) begin
                  h_d = '0;
                  v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
               end else begin
                  h_d = h_q + HW'(1);
               end
               de_d = active;
               hs_d = hs_win ? HS_ACT : ~HS_ACT;
               vs_d = vs_win ? VS_ACT : ~VS_ACT;

               if (state_q == ST_SYNC) begin
                  // Discard stale beats; hold a start-of-frame beat until the raster reaches (0,0).
                  if (!empty) begin
                     if (!head.tuser) begin
                        pop = 1'b1;
                     end else if (sof) begin
                        pop     = 1'b1;
                        data_d  = head.tdata;
                        state_d = ST_LOCKED;
                     end
                  end
               end else if (active) begin
                  if (empty || mismatch) begin
                     state_d = ST_SYNC;
                     uf_d    = 1'b1;
                  end else begin
                     pop    = 1'b1;
                     data_d = head.tdata;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
      wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(wr_en);
      rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         h_q      <= '0;
         v_q      <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         data_q   <= '0;
         de_q     <= 1'b0;
         hs_q     <= ~HS_ACT;
         vs_q     <= ~VS_ACT;
         locked_q <= 1'b0;
         uf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         v_q      <= v_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         data_q   <= data_d;
         de_q     <= de_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         locked_q <= locked_d;
         uf_q     <= uf_d;
      end
   end

   assign vid_data_o  = data_q;
   assign vid_de_o    = de_q;
   assign vid_hsync_o = hs_q;
   assign vid_vsync_o = vs_q;
   assign locked_o    = locked_q;
   assign underflow_o = uf_q;

endmodule
